memory_access: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of instruction_execute and consumes its EX/MEM outputs.
- Holds the byte-addressable data memory and performs byte, halfword and word loads and stores, with sign or zero extension on loads.
- Registers results into the MEM/WB pipeline register that feeds write-back.
- Provides a combinational word read port for the debug unit.

---
 rtl/memory_access.sv | 129 ++++++++++++
 tb/tb_memory_access.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// MEM stage of the 5-stage MIPS pipeline.
// Holds a byte-addressable, little-endian data memory of MEM_DEPTH 32-bit words and performs
// byte/halfword/word loads (sign or zero extended) and stores. Results are registered into the
// MEM/WB pipeline register. A combinational debug port reads any word by index.
//
// Ports:
//   i_clk, i_reset            clock (rising edge), asynchronous active-high reset
//   i_halt                    freezes the stage: no store, MEM/WB register holds
//   i_WB_write, i_WB_mem_to_reg, i_write_reg   write-back controls from EX (passed through)
//   i_MEM_read, i_MEM_write   load / store strobes
//   i_MEM_unsigned            zero-extend loads when 1
//   i_MEM_byte_half_word      access size: 00 byte, 01 half, 1x word
//   i_data_to_write_in_MEM    store data
//   i_ALU_result              byte address for memory ops, pass-through data otherwise
//   i_debug_addr              debug word index
//   o_WB_write, o_WB_mem_to_reg, o_write_reg, o_ALU_result   registered pass-through
//   o_read_data               registered, extended read of the current address
//   o_debug_data              combinational mem[i_debug_addr]
module memory_access #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 64,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_halt,
  input  logic                  i_WB_write,
  input  logic                  i_WB_mem_to_reg,
  input  logic                  i_MEM_read,
  input  logic                  i_MEM_write,
  input  logic                  i_MEM_unsigned,
  input  logic [1:0]            i_MEM_byte_half_word,
  input  logic [4:0]            i_write_reg,
  input  logic [DATA_WIDTH-1:0] i_data_to_write_in_MEM,
  input  logic [DATA_WIDTH-1:0] i_ALU_result,
  input  logic [ADDR_WIDTH-1:0] i_debug_addr,
  output logic                  o_WB_write,
  output logic                  o_WB_mem_to_reg,
  output logic [4:0]            o_write_reg,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic [DATA_WIDTH-1:0] o_ALU_result,
  output logic [DATA_WIDTH-1:0] o_debug_data
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_lane;
  logic [DATA_WIDTH-1:0] w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_read_ext;
  logic [DATA_WIDTH-1:0] w_wmask;
  logic [DATA_WIDTH-1:0] w_wdata;

  // o_read_data always captures the extended read; write-back selects via mem_to_reg.
  logic w_unused_mem_read;
  assign w_unused_mem_read = i_MEM_read;

  // Upper address bits are dropped, so addresses wrap modulo 4*MEM_DEPTH bytes.
  assign w_idx  = i_ALU_result[ADDR_WIDTH+1:2];
  assign w_lane = i_ALU_result[1:0];
  assign w_word = r_mem[w_idx];

  always_comb begin
    w_byte = 8'h00;
    unique case (w_lane)
      2'd0: w_byte = w_word[7:0];
      2'd1: w_byte = w_word[15:8];
      2'd2: w_byte = w_word[23:16];
      2'd3: w_byte = w_word[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  // Halfword selection ignores lane bit 0: no misalignment trap.
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_read_ext = w_word;
    w_wmask    = '1;
    w_wdata    = i_data_to_write_in_MEM;
    case (i_MEM_byte_half_word)
      2'b00: begin
        w_read_ext = i_MEM_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        w_wmask    = 32'h0000_00FF << {w_lane, 3'b000};
        w_wdata    = {4{i_data_to_write_in_MEM[7:0]}};
      end
      2'b01: begin
        w_read_ext = i_MEM_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        w_wmask    = w_lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        w_wdata    = {2{i_data_to_write_in_MEM[15:0]}};
      end
      default: begin
        // 2'b10 is treated as a word access
        w_read_ext = w_word;
        w_wmask    = '1;
        w_wdata    = i_data_to_write_in_MEM;
      end
    endcase
  end

  // Memory and MEM/WB register share one process so reset clears both in the same instant.
  // The read above samples pre-store contents, giving read-before-write on a combined access.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      o_WB_write      <= 1'b0;
      o_WB_mem_to_reg <= 1'b0;
      o_write_reg     <= 5'd0;
      o_read_data     <= '0;
      o_ALU_result    <= '0;
    end else if (!i_halt) begin
      if (i_MEM_write) begin
        r_mem[w_idx] <= (w_word & ~w_wmask) | (w_wdata & w_wmask);
      end
      o_WB_write      <= i_WB_write;
      o_WB_mem_to_reg <= i_WB_mem_to_reg;
      o_write_reg     <= i_write_reg;
      o_read_data     <= w_read_ext;
      o_ALU_result    <= i_ALU_result;
    end
  end

  assign o_debug_data = r_mem[i_debug_addr];

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halt, wbw, mtr, rd, wr, uns;
  logic [1:0]  sz;
  logic [4:0]  wreg;
  logic [31:0] wdata, alu;
  logic [5:0]  dbg_addr;
  logic        o_wbw, o_mtr;
  logic [4:0]  o_wreg;
  logic [31:0] o_read, o_alu, o_dbg;

  memory_access dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_halt                 (halt),
    .i_WB_write             (wbw),
    .i_WB_mem_to_reg        (mtr),
    .i_MEM_read             (rd),
    .i_MEM_write            (wr),
    .i_MEM_unsigned         (uns),
    .i_MEM_byte_half_word   (sz),
    .i_write_reg            (wreg),
    .i_data_to_write_in_MEM (wdata),
    .i_ALU_result           (alu),
    .i_debug_addr           (dbg_addr),
    .o_WB_write             (o_wbw),
    .o_WB_mem_to_reg        (o_mtr),
    .o_write_reg            (o_wreg),
    .o_read_data            (o_read),
    .o_ALU_result           (o_alu),
    .o_debug_data           (o_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rd, wr, uns;
    logic [1:0]  sz;
    logic        wbw, mtr;
    logic [4:0]  wreg;
    logic [31:0] wdata, alu;
    logic [5:0]  dbg;
    logic [31:0] exp_read, exp_dbg;
  } vec_t;

  function automatic vec_t mk(logic r, logic w, logic u, logic [1:0] s, logic b, logic m,
                              logic [4:0] g, logic [31:0] d, logic [31:0] a, logic [5:0] di,
                              logic [31:0] er, logic [31:0] ed);
    vec_t v;
    v.rd = r; v.wr = w; v.uns = u; v.sz = s; v.wbw = b; v.mtr = m; v.wreg = g;
    v.wdata = d; v.alu = a; v.dbg = di; v.exp_read = er; v.exp_dbg = ed;
    return v;
  endfunction

  // Behavioural model: flat little-endian byte array of 4*64 bytes.
  logic [7:0] mb [256];

  function automatic logic [31:0] mdl_read(logic [31:0] a, logic [1:0] s, logic u);
    int unsigned ad = a % 256;
    int unsigned base;
    logic [7:0]  b;
    logic [15:0] h;
    if (s == 2'b00) begin
      b = mb[ad];
      return u ? {24'h0, b} : {{24{b[7]}}, b};
    end else if (s == 2'b01) begin
      base = ad - (ad % 2);
      h = {mb[base+1], mb[base]};
      return u ? {16'h0, h} : {{16{h[15]}}, h};
    end
    base = ad - (ad % 4);
    return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
  endfunction

  task automatic mdl_store(logic [31:0] a, logic [1:0] s, logic [31:0] d);
    int unsigned ad = a % 256;
    int unsigned n = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    int unsigned base = ad - (ad % n);
    for (int k = 0; k < n; k++) mb[base+k] = d[8*k +: 8];
  endtask

  function automatic logic [31:0] mdl_word(logic [5:0] i);
    return {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]};
  endfunction

  task automatic drive(logic h, logic r, logic w, logic u, logic [1:0] s, logic b, logic m,
                       logic [4:0] g, logic [31:0] d, logic [31:0] a, logic [5:0] di);
    halt = h; rd = r; wr = w; uns = u; sz = s; wbw = b; mtr = m; wreg = g;
    wdata = d; alu = a; dbg_addr = di;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(string tag, logic b, logic m, logic [4:0] g, logic [31:0] rdv,
                            logic [31:0] av);
    check({tag, " wb_write"}, {31'h0, o_wbw}, {31'h0, b});
    check({tag, " mem_to_reg"}, {31'h0, o_mtr}, {31'h0, m});
    check({tag, " write_reg"}, {27'h0, o_wreg}, {27'h0, g});
    check({tag, " read_data"}, o_read, rdv);
    check({tag, " alu_result"}, o_alu, av);
  endtask

  vec_t vecs[14];

  initial begin
    vec_t lv;
    logic        e_wbw, e_mtr;
    logic [4:0]  e_wreg;
    logic [31:0] e_read, e_alu, r_read;

    //            rd wr u  sz     wb m  reg    wdata          alu         dbg exp_read       exp_dbg
    vecs[0]  = mk(0, 1, 0, 2'b11, 0, 0, 5'd0,  32'hDEADBEEF, 32'd8,      2, 32'h00000000, 32'hDEADBEEF);
    vecs[1]  = mk(1, 0, 0, 2'b11, 1, 1, 5'd2,  32'h0,        32'd8,      2, 32'hDEADBEEF, 32'hDEADBEEF);
    vecs[2]  = mk(0, 1, 0, 2'b00, 0, 0, 5'd0,  32'h00000080, 32'd17,     4, 32'h00000000, 32'h00008000);
    vecs[3]  = mk(1, 0, 0, 2'b00, 1, 1, 5'd3,  32'h0,        32'd17,     4, 32'hFFFFFF80, 32'h00008000);
    vecs[4]  = mk(1, 0, 1, 2'b00, 1, 1, 5'd4,  32'h0,        32'd17,     4, 32'h00000080, 32'h00008000);
    vecs[5]  = mk(0, 1, 0, 2'b01, 0, 0, 5'd0,  32'h00008001, 32'd22,     5, 32'h00000000, 32'h80010000);
    vecs[6]  = mk(1, 0, 0, 2'b01, 1, 1, 5'd5,  32'h0,        32'd22,     5, 32'hFFFF8001, 32'h80010000);
    vecs[7]  = mk(1, 0, 1, 2'b01, 1, 1, 5'd6,  32'h0,        32'd23,     5, 32'h00008001, 32'h80010000);
    vecs[8]  = mk(0, 0, 0, 2'b11, 1, 0, 5'd31, 32'h0,        32'h11,     4, 32'h00008000, 32'h00008000);
    vecs[9]  = mk(0, 1, 0, 2'b11, 0, 0, 5'd0,  32'hA5A5A5A5, 32'd256,    0, 32'h00000000, 32'hA5A5A5A5);
    vecs[10] = mk(1, 0, 0, 2'b10, 1, 1, 5'd8,  32'h0,        32'h101,    0, 32'hA5A5A5A5, 32'hA5A5A5A5);
    vecs[11] = mk(1, 1, 0, 2'b11, 1, 1, 5'd9,  32'h11223344, 32'd8,      2, 32'hDEADBEEF, 32'h11223344);
    vecs[12] = mk(1, 1, 0, 2'b00, 1, 1, 5'd10, 32'hFFFFFF7F, 32'd11,     2, 32'h00000011, 32'h7F223344);
    vecs[13] = mk(1, 0, 0, 2'b01, 1, 1, 5'd7,  32'h0,        32'd9,      2, 32'h00003344, 32'h7F223344);

    drive(0, 0, 0, 0, 2'b00, 0, 0, 5'd0, 32'h0, 32'h0, 6'd0);
    #1 rst = 1'b1;
    #1;
    check_outs("reset", 0, 0, 5'd0, 32'h0, 32'h0);
    check("reset dbg", o_dbg, 32'h0);
    @(negedge clk) rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      lv = vecs[i];
      drive(0, lv.rd, lv.wr, lv.uns, lv.sz, lv.wbw, lv.mtr, lv.wreg, lv.wdata, lv.alu, lv.dbg);
      step();
      check_outs($sformatf("vec%0d", i), lv.wbw, lv.mtr, lv.wreg, lv.exp_read, lv.alu);
      check($sformatf("vec%0d debug", i), o_dbg, lv.exp_dbg);
    end

    // Halt with a pending store to word 0: nothing moves for two edges
    lv = vecs[13];
    drive(1, 0, 1, 0, 2'b11, 0, 0, 5'd3, 32'h12345678, 32'h0, 6'd0);
    for (int c = 0; c < 2; c++) begin
      step();
      check_outs($sformatf("halt%0d", c), lv.wbw, lv.mtr, lv.wreg, lv.exp_read, lv.alu);
      check($sformatf("halt%0d word0", c), o_dbg, 32'hA5A5A5A5);
    end
    halt = 1'b0;
    step();
    check_outs("unhalt", 0, 0, 5'd3, 32'hA5A5A5A5, 32'h0);
    check("unhalt word0", o_dbg, 32'h12345678);

    // Reset between edges after several stores
    drive(0, 0, 1, 0, 2'b11, 1, 1, 5'd12, 32'hCAFEF00D, 32'd40, 6'd10);
    step();
    #2 rst = 1'b1;
    #1;
    check_outs("midreset", 0, 0, 5'd0, 32'h0, 32'h0);
    for (int i = 0; i < 64; i++) begin
      dbg_addr = 6'(i);
      #1;
      check($sformatf("midreset dbg%0d", i), o_dbg, 32'h0);
    end
    @(negedge clk) rst = 1'b0;

    // Randomized run against the byte-array model
    for (int i = 0; i < 256; i++) mb[i] = 8'h00;
    e_wbw = 0; e_mtr = 0; e_wreg = 0; e_read = 0; e_alu = 0;
    for (int t = 0; t < 400; t++) begin
      drive(($urandom % 8) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom), $urandom,
            (($urandom % 4) == 0) ? $urandom : $urandom_range(0, 255), 6'($urandom));
      r_read = mdl_read(alu, sz, uns);
      if (!halt) begin
        e_wbw = wbw; e_mtr = mtr; e_wreg = wreg; e_read = r_read; e_alu = alu;
        if (wr) mdl_store(alu, sz, wdata);
      end
      step();
      check_outs($sformatf("rnd%0d", t), e_wbw, e_mtr, e_wreg, e_read, e_alu);
      check($sformatf("rnd%0d debug", t), o_dbg, mdl_word(dbg_addr));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
